// File: rtl/edge_detect_multi.sv
// N-channel debounced edge detector: per-channel synchroniser, filter FSM and
// mode-gated tick, plus sticky pending flags and an OR'd interrupt.

module edge_detect_ch #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       level_i,
    input  logic [1:0] mode_i,
    output logic       ticc_o,
    output logic       filt_o
);

    localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_LOW  = 2'd0,
        ST_RISE = 2'd1,
        ST_HIGH = 2'd2,
        ST_FALL = 2'd3
    } state_e;

    logic [SYNC_STAGES-1:0] sync_q;
    state_e                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   s;

    assign s = sync_q[SYNC_STAGES-1];

    // RISE/FALL are single-cycle marker states; the counter only restarts
    // once the FSM has settled into HIGH/LOW.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q  <= '0;
            state_q <= ST_LOW;
            cnt_q   <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], level_i};
            case (state_q)
                ST_LOW: begin
                    if (!s) begin
                        cnt_q <= '0;
                    end else if (cnt_q == CNT_MAX) begin
                        state_q <= ST_RISE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                ST_RISE: begin
                    state_q <= ST_HIGH;
                    cnt_q   <= '0;
                end
                ST_HIGH: begin
                    if (s) begin
                        cnt_q <= '0;
                    end else if (cnt_q == CNT_MAX) begin
                        state_q <= ST_FALL;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                ST_FALL: begin
                    state_q <= ST_LOW;
                    cnt_q   <= '0;
                end
                default: begin
                    state_q <= ST_LOW;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // Mode only gates the tick; the filter keeps tracking even when off.
    assign filt_o = (state_q == ST_RISE) || (state_q == ST_HIGH);
    assign ticc_o = ((state_q == ST_RISE) && mode_i[0]) ||
                    ((state_q == ST_FALL) && mode_i[1]);

endmodule

module edge_detect_multi #(
    parameter int N           = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   level,
    input  logic [2*N-1:0] mode,
    input  logic [N-1:0]   clr,
    output logic [N-1:0]   ticc,
    output logic [N-1:0]   filt,
    output logic [N-1:0]   pend,
    output logic           irq
);

    logic [N-1:0] pend_q;
    logic [N-1:0] pend_d;

    for (genvar g = 0; g < N; g++) begin : g_ch
        edge_detect_ch #(
            .SYNC_STAGES(SYNC_STAGES),
            .FILTER_LEN (FILTER_LEN)
        ) u_ch (
            .clk    (clk),
            .reset  (reset),
            .level_i(level[g]),
            .mode_i (mode[2*g+1:2*g]),
            .ticc_o (ticc[g]),
            .filt_o (filt[g])
        );
    end

    // A tick in the same cycle as a clear keeps the flag set.
    assign pend_d = (pend_q & ~clr) | ticc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign pend = pend_q;
    assign irq  = |pend_q;

endmodule

// File: tb/tb_edge_detect_multi.sv
// Bench for edge_detect_multi: directed scenarios with literal expectations
// plus randomized levels/modes/clears checked every cycle against a window model.

module tb_edge_detect_multi;

  localparam int N  = 4;
  localparam int SS = 2;
  localparam int FL = 3;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [N-1:0]   level = '0;
  logic [2*N-1:0] mode = 8'h55;
  logic [N-1:0]   clr = '0;
  logic [N-1:0]   ticc;
  logic [N-1:0]   filt;
  logic [N-1:0]   pend;
  logic           irq;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  edge_detect_multi #(.N(N), .SYNC_STAGES(SS), .FILTER_LEN(FL)) dut (
    .clk  (clk),
    .reset(reset),
    .level(level),
    .mode (mode),
    .clr  (clr),
    .ticc (ticc),
    .filt (filt),
    .pend (pend),
    .irq  (irq)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the synchroniser is a queue delay line; a channel accepts
  // a new level when the last FL synchronised samples all differ from the
  // accepted level and none of them fall in the marker cycle or the cycle before.
  logic [N-1:0] pipe_q[$];
  logic [N-1:0] s_win[$];
  logic [N-1:0] m_acc = '0;
  logic [N-1:0] m_rise = '0;
  logic [N-1:0] m_fall = '0;
  logic [N-1:0] m_pend = '0;
  int           m_t = 0;
  int           m_ta[N];

  function automatic logic [N-1:0] exp_ticc(input logic [N-1:0] r, input logic [N-1:0] f,
                                            input logic [2*N-1:0] md);
    logic [N-1:0] v;
    v = '0;
    for (int c = 0; c < N; c++) v[c] = (r[c] & md[2*c]) | (f[c] & md[2*c+1]);
    return v;
  endfunction

  task automatic model_reset();
    pipe_q = {};
    s_win = {};
    for (int i = 0; i < SS; i++) pipe_q.push_back('0);
    for (int i = 0; i < FL; i++) s_win.push_back('0);
    m_acc = '0;
    m_rise = '0;
    m_fall = '0;
    m_pend = '0;
    m_t = 0;
    for (int c = 0; c < N; c++) m_ta[c] = -100;
  endtask

  task automatic model_step();
    logic [N-1:0] s_now;
    logic [N-1:0] dummy;
    bit all_diff;
    m_pend = (m_pend & ~clr) | exp_ticc(m_rise, m_fall, mode);
    s_now = pipe_q.pop_front();
    pipe_q.push_back(level);
    dummy = s_win.pop_front();
    s_win.push_back(s_now);
    m_t++;
    m_rise = '0;
    m_fall = '0;
    for (int c = 0; c < N; c++) begin
      if (m_t - m_ta[c] >= FL + 1) begin
        all_diff = 1'b1;
        foreach (s_win[k]) if (s_win[k][c] == m_acc[c]) all_diff = 1'b0;
        if (all_diff) begin
          m_acc[c] = ~m_acc[c];
          if (m_acc[c]) m_rise[c] = 1'b1;
          else m_fall[c] = 1'b1;
          m_ta[c] = m_t;
        end
      end
    end
  endtask

  initial model_reset();

  always @(posedge clk or negedge reset) begin
    if (!reset) model_reset();
    else model_step();
  end

  // scoreboard compare on the falling edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("ticc", 32'(ticc), 32'(exp_ticc(m_rise, m_fall, mode)));
      check("filt", 32'(filt), 32'(m_acc));
      check("pend", 32'(pend), 32'(m_pend));
      check("irq", 32'(irq), 32'(|m_pend));
    end
  end

  // driver helpers
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic count_ticks(input int ch, input int cycles, output int n);
    n = 0;
    repeat (cycles) begin
      @(posedge clk);
      #3;
      if (ticc[ch]) n++;
    end
  endtask

  int n1, n2, n_all, n_bad;

  initial begin
    // reset state
    step(3);
    check("rst_ticc", 32'(ticc), 0);
    check("rst_filt", 32'(filt), 0);
    check("rst_pend", 32'(pend), 0);
    check("rst_irq", 32'(irq), 0);
    chk_en = 1'b1;
    reset = 1'b1;
    step(2);

    // 1: single rise, tick exactly after edge 5
    level[0] = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk);
      #3;
      check("t1_ticc", 32'(ticc), (k == 5) ? 32'h1 : 32'h0);
      check("t1_filt0", 32'(filt[0]), (k >= 5) ? 32'h1 : 32'h0);
    end
    check("t1_pend", 32'(pend), 32'h1);
    check("t1_irq", 32'(irq), 32'h1);

    // 2: glitch rejection on ch1
    step(1);
    level[1] = 1'b1;
    step(2);
    level[1] = 1'b0;
    count_ticks(1, 12, n1);
    check("t2_glitch_ticks", 32'(n1), 0);
    check("t2_glitch_filt", 32'(filt[1]), 0);
    check("t2_glitch_pend", 32'(pend[1]), 0);
    level[1] = 1'b1;
    step(3);
    level[1] = 1'b0;
    count_ticks(1, 12, n1);
    check("t2_pulse3_ticks", 32'(n1), 1);
    check("t2_pulse3_pend", 32'(pend[1]), 1);

    // 3: fall-only then both on ch2
    mode = 8'h65;
    level[2] = 1'b1;
    count_ticks(2, 10, n1);
    check("t3_fall_rise_ticks", 32'(n1), 0);
    check("t3_filt_high", 32'(filt[2]), 1);
    level[2] = 1'b0;
    count_ticks(2, 10, n2);
    check("t3_fall_ticks", 32'(n2), 1);
    check("t3_filt_low", 32'(filt[2]), 0);
    mode = 8'h75;
    level[2] = 1'b1;
    count_ticks(2, 10, n1);
    level[2] = 1'b0;
    count_ticks(2, 10, n2);
    check("t3_both_ticks", 32'(n1 + n2), 2);

    // 4: clear racing a tick, then a lone clear
    step(1);
    clr = '1;
    step(1);
    clr = '0;
    #1;
    check("t4_clr_all_pend", 32'(pend), 0);
    check("t4_clr_all_irq", 32'(irq), 0);
    mode = 8'h77;
    level[0] = 1'b0;
    step(5);
    check("t4_ticc0", 32'(ticc[0]), 1);
    clr = 4'b0001;
    step(1);
    clr = '0;
    #1;
    check("t4_set_wins", 32'(pend[0]), 1);
    step(3);
    clr = 4'b0001;
    step(1);
    clr = '0;
    #1;
    check("t4_lone_clr_pend", 32'(pend), 0);
    check("t4_lone_clr_irq", 32'(irq), 0);

    // 5: async reset mid-filter on ch3
    step(1);
    level = 4'b0011;
    step(10);
    check("t5_pre_filt", 32'(filt), 32'h3);
    clr = '1;
    step(1);
    clr = '0;
    level = 4'b1011;
    step(4);
    reset = 1'b0;
    #1;
    check("t5_ticc", 32'(ticc), 0);
    check("t5_filt", 32'(filt), 0);
    check("t5_pend", 32'(pend), 0);
    check("t5_irq", 32'(irq), 0);
    level = 4'b0000;
    step(1);
    reset = 1'b1;
    n_all = 0;
    repeat (12) begin
      @(posedge clk);
      #3;
      if (ticc != '0) n_all++;
    end
    check("t5_no_tick", 32'(n_all), 0);

    // 6: all channels together, both directions
    mode = 8'hFF;
    for (int dir = 0; dir < 2; dir++) begin
      level = (dir == 0) ? 4'b1111 : 4'b0000;
      n_all = 0;
      n_bad = 0;
      repeat (10) begin
        @(posedge clk);
        #3;
        if (ticc == 4'b1111) n_all++;
        else if (ticc != '0) n_bad++;
      end
      check("t6_all_tick", 32'(n_all), 1);
      check("t6_partial_tick", 32'(n_bad), 0);
    end

    // randomized phase, with one mid-run async reset
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #2;
      for (int c = 0; c < N; c++) if ($urandom_range(0, 5) == 0) level[c] = ~level[c];
      if ($urandom_range(0, 39) == 0) mode = 8'($urandom);
      clr = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
      if (i == 1500) begin
        #1 reset = 1'b0;
        #3 reset = 1'b1;
      end
    end

    step(2);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
